// File: rtl/io_irq_hub.sv
// Memory-mapped I/O hub: page-based device strobes, registered read mux,
// and an edge-latched interrupt controller with fixed or rotating priority.
module io_irq_hub #(
    parameter int unsigned CHANNELS    = 4,
    parameter logic [3:0]  BASE_PAGE   = 4'h8,
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              cpu_waddr,
    input  logic [15:0]              cpu_wdata,
    input  logic                     cpu_wenable,
    input  logic [15:0]              cpu_raddr,
    output logic [15:0]              cpu_rdata,
    output logic                     cpu_irq,
    input  logic                     cpu_irq_ack,
    output logic [2:0]               irq_vector,
    output logic [15:0]              dev_waddr,
    output logic [15:0]              dev_wdata,
    output logic [CHANNELS-1:0]      dev_wenable,
    output logic [15:0]              dev_raddr,
    input  logic [16*CHANNELS-1:0]   dev_rdata,
    input  logic [CHANNELS-1:0]      dev_irq
);

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q, prev_q;
    logic [CHANNELS-1:0] rise, req, w1c, ack_clr;
    logic [2:0]          active_q, active_d;
    logic [2:0]          rr_q, rr_d;
    logic [2:0]          winner;
    logic                found;
    logic [15:0]         rdata_q, rdata_d;
    logic                hub_we;

    assign dev_waddr  = {4'h0, cpu_waddr[11:0]};
    assign dev_wdata  = cpu_wdata;
    assign dev_raddr  = {4'h0, cpu_raddr[11:0]};
    assign cpu_rdata  = rdata_q;
    assign irq_vector = active_q;
    // Decoded from state so an asynchronous reset drops the request at once.
    assign cpu_irq    = (state_q == SERVICE);

    assign hub_we = cpu_wenable && (cpu_waddr[15:12] == 4'hF);
    assign rise   = sync2_q & ~prev_q;
    assign req    = pending_q & mask_q;

    always_comb begin
        dev_wenable = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(cpu_waddr[15:12]) == 32'(BASE_PAGE) + i)
                dev_wenable[i] = cpu_wenable;
        end
    end

    // Two passes give a circular search beginning at the rotation pointer.
    always_comb begin
        int unsigned start;
        start  = ROUND_ROBIN ? 32'(rr_q) : 0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (!found && req[j] && j >= start) begin
                found  = 1'b1;
                winner = 3'(j);
            end
        end
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = 3'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rr_d     = rr_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = SERVICE;
                    active_d = winner;
                    rr_d     = (32'(winner) == CHANNELS - 1) ? 3'd0 : winner + 3'd1;
                end
            end
            SERVICE: begin
                if (cpu_irq_ack) begin
                    state_d = IDLE;
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (32'(active_q) == i)
                            ack_clr[i] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        w1c    = '0;
        if (hub_we && cpu_waddr[11:0] == 12'h000)
            mask_d = cpu_wdata[CHANNELS-1:0];
        if (hub_we && cpu_waddr[11:0] == 12'h001)
            w1c = cpu_wdata[CHANNELS-1:0];
        // A fresh edge outranks any clear landing in the same cycle.
        pending_d = (pending_q & ~(w1c | ack_clr)) | rise;
    end

    always_comb begin
        rdata_d = '0;
        if (cpu_raddr[15:12] == 4'hF) begin
            case (cpu_raddr[11:0])
                12'h000: rdata_d[CHANNELS-1:0] = mask_q;
                12'h001: rdata_d[CHANNELS-1:0] = pending_q;
                12'h002: rdata_d = {state_q == SERVICE, 12'h000, active_q};
                default: rdata_d = '0;
            endcase
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (32'(cpu_raddr[15:12]) == 32'(BASE_PAGE) + i)
                    rdata_d = dev_rdata[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mask_q    <= '1;
            pending_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            active_q  <= '0;
            rr_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            sync1_q   <= dev_irq;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            active_q  <= active_d;
            rr_q      <= rr_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_io_irq_hub.sv
// Directed scoreboard bench for io_irq_hub: a fixed-priority and a
// round-robin instance share the CPU bus; each has its own irq/ack lines.
module tb_io_irq_hub;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_waddr, cpu_wdata, cpu_raddr;
    logic        cpu_wenable;
    logic [63:0] dev_rdata;

    logic [15:0] cpu_rdata, dev_waddr, dev_wdata, dev_raddr;
    logic        cpu_irq, cpu_irq_ack;
    logic [2:0]  irq_vector;
    logic [3:0]  dev_wenable, dev_irq;

    logic [15:0] rdata_rr, waddr_rr, wdata_rr, raddr_rr;
    logic        irq_rr, ack_rr;
    logic [2:0]  vec_rr;
    logic [3:0]  wen_rr, dev_irq_rr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] d;
    logic [2:0]  rr_order [4] = '{3'd0, 3'd1, 3'd3, 3'd0};

    io_irq_hub #(.CHANNELS(4), .BASE_PAGE(4'h8), .ROUND_ROBIN(1'b0)) dut (
        .clock(clock), .reset(reset),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wenable(cpu_wenable),
        .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
        .cpu_irq(cpu_irq), .cpu_irq_ack(cpu_irq_ack), .irq_vector(irq_vector),
        .dev_waddr(dev_waddr), .dev_wdata(dev_wdata), .dev_wenable(dev_wenable),
        .dev_raddr(dev_raddr), .dev_rdata(dev_rdata), .dev_irq(dev_irq)
    );

    io_irq_hub #(.CHANNELS(4), .BASE_PAGE(4'h8), .ROUND_ROBIN(1'b1)) dut_rr (
        .clock(clock), .reset(reset),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wenable(cpu_wenable),
        .cpu_raddr(cpu_raddr), .cpu_rdata(rdata_rr),
        .cpu_irq(irq_rr), .cpu_irq_ack(ack_rr), .irq_vector(vec_rr),
        .dev_waddr(waddr_rr), .dev_wdata(wdata_rr), .dev_wenable(wen_rr),
        .dev_raddr(raddr_rr), .dev_rdata(dev_rdata), .dev_irq(dev_irq_rr)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] v);
        cpu_waddr   = a;
        cpu_wdata   = v;
        cpu_wenable = 1'b1;
        tick();
        cpu_wenable = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] v);
        cpu_raddr = a;
        tick();
        v = cpu_rdata;
    endtask

    task automatic wait_irq(input bit rr);
        for (int c = 0; c < 30; c++) begin
            if ((rr ? irq_rr : cpu_irq) === 1'b1) return;
            tick();
        end
    endtask

    initial begin
        reset       = 1'b0;
        cpu_waddr   = '0;
        cpu_wdata   = '0;
        cpu_wenable = 1'b0;
        cpu_raddr   = '0;
        cpu_irq_ack = 1'b0;
        ack_rr      = 1'b0;
        dev_irq     = '0;
        dev_irq_rr  = '0;
        dev_rdata   = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        #22 reset = 1'b1;
        tick();

        push("rst_rdata", 0); push("rst_irq", 0); push("rst_vec", 0);
        pop_check(cpu_rdata); pop_check(cpu_irq); pop_check(irq_vector);

        // write decode is combinational
        cpu_waddr = 16'h8005; cpu_wdata = 16'h1234; cpu_wenable = 1'b1;
        push("wen_ch0", 4'b0001); push("dev_waddr", 16'h0005); push("dev_wdata", 16'h1234);
        #1;
        pop_check(dev_wenable); pop_check(dev_waddr); pop_check(dev_wdata);
        tick();
        cpu_waddr = 16'hB123; push("wen_ch3", 4'b1000);
        #1 pop_check(dev_wenable);
        tick();
        cpu_waddr = 16'hC000; push("wen_page_c", 4'b0000);
        #1 pop_check(dev_wenable);
        tick();
        cpu_waddr = 16'hF000; cpu_wdata = 16'h000F; push("wen_hub", 4'b0000);
        #1 pop_check(dev_wenable);
        tick();
        cpu_wenable = 1'b0;

        cpu_raddr = 16'h9ABC; push("dev_raddr", 16'h0ABC);
        #1 pop_check(dev_raddr);
        push("rd_ch1", 16'hBEEF);   cpu_read(16'h9000, d); pop_check(d);
        push("rd_ch3", 16'h4444);   cpu_read(16'hB010, d); pop_check(d);
        push("rd_unmap", 16'h0000); cpu_read(16'h3000, d); pop_check(d);
        push("rd_mask", 16'h000F);  cpu_read(16'hF000, d); pop_check(d);
        push("rd_stat0", 16'h0000); cpu_read(16'hF002, d); pop_check(d);
        push("rd_hub_unused", 0);   cpu_read(16'hF003, d); pop_check(d);

        // fixed priority with exact interrupt latency
        dev_irq = 4'b0110;
        push("lat_k2_low", 0); push("lat_k3_irq", 1); push("fp_vec1", 1);
        tick(); tick();
        dev_irq = '0;
        tick();
        pop_check(cpu_irq);
        tick();
        pop_check(cpu_irq); pop_check(irq_vector);

        cpu_irq_ack = 1'b1;
        push("ack_low", 0); push("vec_hold", 1); push("regrant_irq", 1); push("fp_vec2", 2);
        tick();
        cpu_irq_ack = 1'b0;
        pop_check(cpu_irq); pop_check(irq_vector);
        tick();
        pop_check(cpu_irq); pop_check(irq_vector);
        push("pend_b4_ack", 4'b0100); cpu_read(16'hF001, d); pop_check(d);
        push("stat_svc", 16'h8002);   cpu_read(16'hF002, d); pop_check(d);
        cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
        push("pend_after", 0);        cpu_read(16'hF001, d); pop_check(d);
        push("stat_idle", 16'h0002);  cpu_read(16'hF002, d); pop_check(d);
        push("idle_irq", 0);          pop_check(cpu_irq);

        cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
        push("ack_idle_irq", 0); push("ack_idle_vec", 2);
        pop_check(cpu_irq); pop_check(irq_vector);

        // mask and write-1-to-clear
        cpu_write(16'hF000, 16'h000E);
        dev_irq = 4'b0001; tick(); tick(); dev_irq = '0;
        repeat (6) tick();
        push("masked_noirq", 0);     pop_check(cpu_irq);
        push("masked_pend", 4'b0001); cpu_read(16'hF001, d); pop_check(d);
        cpu_write(16'hF001, 16'h0001);
        push("w1c_pend", 0);         cpu_read(16'hF001, d); pop_check(d);
        cpu_write(16'hF000, 16'h000F);
        repeat (4) tick();
        push("unmask_noirq", 0);     pop_check(cpu_irq);
        push("mask_rd", 16'h000F);   cpu_read(16'hF000, d); pop_check(d);

        // edge landing in the same cycle as the ack of the same channel
        dev_irq = 4'b0010;
        push("col_irq1", 1); push("col_vec1", 1);
        wait_irq(1'b0);
        pop_check(cpu_irq); pop_check(irq_vector);
        dev_irq = '0;
        repeat (4) tick();
        dev_irq = 4'b0010;
        tick(); tick();
        cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
        push("col_low", 0); pop_check(cpu_irq);
        tick();
        push("col_regrant", 1); push("col_vec2", 1);
        pop_check(cpu_irq); pop_check(irq_vector);
        push("col_pend", 4'b0010); cpu_read(16'hF001, d); pop_check(d);
        cpu_write(16'hF001, 16'h0002);
        push("w1c_keeps_irq", 1);  pop_check(cpu_irq);
        cpu_write(16'hF000, 16'h000D);
        push("mask_keeps_irq", 1); pop_check(cpu_irq);
        cpu_write(16'hF000, 16'h000F);
        cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
        repeat (6) tick();
        push("level_no_retrig", 0); pop_check(cpu_irq);
        dev_irq = '0;

        // rotating priority on the second instance
        dev_irq_rr = 4'b1011; tick(); tick(); dev_irq_rr = '0;
        for (int n = 0; n < 4; n++) begin
            push("rr_irq", 1); push($sformatf("rr_vec%0d", n), 32'(rr_order[n]));
            wait_irq(1'b1);
            pop_check(irq_rr); pop_check(vec_rr);
            ack_rr = 1'b1; tick(); ack_rr = 1'b0;
            dev_irq_rr = 4'b0001 << rr_order[n];
            tick(); tick();
            dev_irq_rr = '0;
        end

        // asynchronous reset while in service
        dev_irq = 4'b1000;
        push("rs_irq", 1); push("rs_vec", 3);
        wait_irq(1'b0);
        pop_check(cpu_irq); pop_check(irq_vector);
        dev_irq = '0;
        #2 reset = 1'b0;
        #1;
        push("rs_drop_irq", 0); push("rs_vec0", 0);
        pop_check(cpu_irq); pop_check(irq_vector);
        tick(); tick();
        reset = 1'b1;
        push("rs_stat", 0);         cpu_read(16'hF002, d); pop_check(d);
        push("rs_pend", 0);         cpu_read(16'hF001, d); pop_check(d);
        push("rs_mask", 16'h000F);  cpu_read(16'hF000, d); pop_check(d);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_irq_hub.md
# io_irq_hub

Parametrised memory-mapped I/O hub and interrupt controller that sits between the CPU datapath and N peripheral drivers (keyboard, VGA, future timers/UART). It replaces the fixed one-interface-per-device wiring at the top level. It decodes CPU read/write addresses into per-channel device strobes and returns registered read data. It latches device interrupt edges into a pending vector and arbitrates them, by fixed or round-robin priority, into the single CPU `irq`/`reset_irq` pair.

## Interface
- CHANNELS, 4, number of device channels, 1..8
- BASE_PAGE, 4'h8, page of channel 0; channel i owns page BASE_PAGE+i; BASE_PAGE+CHANNELS <= 15
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = rotating priority
- clock  in  1  system clock; everything is clocked on its rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_waddr  in  16  CPU write address
- cpu_wdata  in  16  CPU write data
- cpu_wenable  in  1  CPU write strobe
- cpu_raddr  in  16  CPU read address
- cpu_rdata  out  16  registered read data
- cpu_irq  out  1  interrupt request to the control path
- cpu_irq_ack  in  1  single-cycle acknowledge (the control path's reset_irq)
- irq_vector  out  3  index of the in-service channel
- dev_waddr  out  16  shared write offset: {4'h0, cpu_waddr[11:0]}
- dev_wdata  out  16  shared write data, equal to cpu_wdata
- dev_wenable  out  CHANNELS  one-hot per-channel write strobe
- dev_raddr  out  16  shared read offset: {4'h0, cpu_raddr[11:0]}
- dev_rdata  in  16*CHANNELS  per-channel read data; channel i occupies bits [16i+15:16i]
- dev_irq  in  CHANNELS  per-channel interrupt level; may be asynchronous to clock

## Operation
- **Write decode (combinational):**
  - dev_wenable[i] = cpu_wenable when cpu_waddr[15:12] == BASE_PAGE+i; otherwise 0.
  - Page 4'hF addresses hub registers, written on the clock edge.
  - Writes to other pages are ignored.
- **Hub registers:**
  - 16'hF000 MASK: bits [CHANNELS-1:0] read/write; 1 = enabled.
  - 16'hF001 PENDING: read; writing 1 to a bit clears it.
  - 16'hF002 STATUS: read-only; bit 15 = in_service, bits [2:0] = active id, all other bits 0.
  - Unused bits read 0.
- **Read path:**
  - Each edge, cpu_rdata captures the selected dev_rdata slice or hub register.
  - Unmapped pages and unused hub offsets return 16'h0000.
- **Interrupt capture:**
  - dev_irq[i] passes through a 2-flop synchroniser, then a rising-edge detector.
  - A detected edge sets pending[i].
  - Level-held inputs do not re-trigger.
- **Arbitration states:**
  - IDLE: if (pending & MASK) != 0, select the winner and go to SERVICE. active_id <= winner; cpu_irq <= 1.
  - SERVICE: cpu_irq is held at 1. On cpu_irq_ack: pending[active_id] <= 0, cpu_irq <= 0, go to IDLE.
- **Winner selection:**
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at (last granted id + 1) mod CHANNELS.
- irq_vector = active_id. It holds its value after ack until the next grant.
- **Boundary cases:**
  - Ack in IDLE is ignored.
  - A new edge on channel i in the same cycle as the ack or W1C of channel i: the set wins and pending[i] stays 1.
  - Clearing a MASK bit of the in-service channel does not drop cpu_irq.
  - W1C of the in-service channel's pending bit does not end SERVICE; only the ack does.
  - A write to page 4'hF never asserts any dev_wenable.
- **Reset (asynchronous) values:**
  - Outputs: cpu_rdata = 0, cpu_irq = 0, irq_vector = 0.
  - State: pending = 0, MASK = all ones, state = IDLE, round-robin pointer = 0, synchronisers and edge registers = 0.
  - Reset mid-SERVICE drops cpu_irq immediately, without waiting for a clock edge.

## Timing
- dev_wenable, dev_waddr, dev_wdata, dev_raddr: combinational, same cycle as the CPU inputs.
- cpu_rdata: 1-cycle latency. The data for cpu_raddr presented in cycle n is valid after edge n+1.
- Interrupt path: dev_irq rises and is sampled at edge k.
  - Edge k+2: pending set.
  - Edge k+3: cpu_irq = 1.
- Ack at edge a:
  - cpu_irq = 0 after edge a.
  - Earliest re-grant at edge a+1, giving at least one low cycle between requests.
- Hub register writes take effect at the edge where cpu_wenable is sampled. A read of the same register in the next cycle returns the new value.

## Test plan
- **Write decode, readback, unmapped:** Defaults, write 16'h1234 to 16'h8005 → dev_wenable = 4'b0001, dev_waddr = 16'h0005 in that cycle. dev_rdata[31:16] = 16'hBEEF with read of 16'h9000 → cpu_rdata = 16'hBEEF one edge later. Read of 16'h3000 → 16'h0000.
- **Fixed priority:** Pulse dev_irq[2] and dev_irq[1] together → grant id 1. Ack → cpu_irq low for one cycle, then grant id 2. PENDING reads 4'b0100 before the second ack and 0 after it.
- **Round robin (ROUND_ROBIN=1):** Hold pending = 4'b1011 and ack each grant in turn, re-triggering each channel after its ack → grant order 0, 1, 3, 0.
- **Mask and W1C:** Write MASK = 4'b1110, then pulse dev_irq[0] → no cpu_irq; PENDING = 4'b0001. Write 16'h0001 to 16'hF001 → PENDING = 0. Write MASK = 4'b1111 → still no cpu_irq.
- **Collision:** New dev_irq[1] edge lands in the same cycle as the ack of id 1 → pending[1] stays 1, and id 1 is re-granted one cycle after the low cycle.
- **Reset mid-service:** Assert reset asynchronously while in SERVICE → cpu_irq goes 0 before the next edge. After release: STATUS = 0, PENDING = 0, MASK = 4'b1111.
